// File: rtl/and_gate_sequencer.sv
// rtl/and_gate_sequencer.sv - truth-table self-test controller for a 2-input and_gate
module and_gate_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int DWELL_CYCLES  = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       gate_f,
    output logic       gate_a,
    output logic       gate_b,
    output logic [1:0] vec_idx,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       fail,
    output logic [3:0] err_mask
);

    localparam int CNT_MAX = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] DWELL_LAST  = CW'(DWELL_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DWELL,
        ST_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          start_q;
    logic          start_rise;

    assign start_rise = start & ~start_q;

    // Remember last start level so a held button only triggers once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
        end else begin
            start_q <= start;
        end
    end

    // Sequencer: walk vectors 00..11, settle, compare F, dwell, then report
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            gate_a   <= 1'b0;
            gate_b   <= 1'b0;
            vec_idx  <= 2'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail     <= 1'b0;
            err_mask <= 4'd0;
        end else if (abort) begin
            // Abort wins over everything, including a simultaneous start edge
            state    <= ST_IDLE;
            cnt      <= '0;
            gate_a   <= 1'b0;
            gate_b   <= 1'b0;
            vec_idx  <= 2'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail     <= 1'b0;
            err_mask <= 4'd0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_rise) begin
                        // Gate inputs and busy are set on entry to APPLY of vector 0
                        state    <= ST_APPLY;
                        vec_idx  <= 2'd0;
                        gate_a   <= 1'b0;
                        gate_b   <= 1'b0;
                        busy     <= 1'b1;
                        err_mask <= 4'd0;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        fail     <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    cnt   <= '0;
                    state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state <= ST_SAMPLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (gate_f != (gate_a & gate_b)) begin
                        err_mask[vec_idx] <= 1'b1;
                    end
                    cnt   <= '0;
                    state <= ST_DWELL;
                end
                ST_DWELL: begin
                    if (cnt != DWELL_LAST) begin
                        cnt <= cnt + CW'(1);
                    end else if (vec_idx == 2'd3) begin
                        // err_mask is already final here: the last SAMPLE preceded this dwell
                        state  <= ST_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        pass   <= ~|err_mask;
                        fail   <= |err_mask;
                        gate_a <= 1'b0;
                        gate_b <= 1'b0;
                    end else begin
                        state   <= ST_APPLY;
                        vec_idx <= vec_idx + 2'd1;
                        {gate_a, gate_b} <= vec_idx + 2'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
